// File: rtl/vga_reg_pkg.sv
// Shared types and default sizing for the VGA display register arbiter.
// The FIFO, the bank and the drain FSM all size themselves from these values.
package vga_reg_pkg;

  localparam int ADDR_W    = 5;
  localparam int DEPTH     = 8;
  localparam int MAX_DRAIN = 16;
  localparam int FC_W      = 16;

  typedef enum logic [1:0] {
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_entry_t;

endpackage

// File: rtl/vga_reg_arbiter_fifo.sv
// Synchronous write FIFO that holds processor writes until the next vertical blank.
// The word at the read pointer is always presented, so a pop consumes that same word.
module reg_write_fifo
  import vga_reg_pkg::*;
#(
  parameter int  DEPTH   = vga_reg_pkg::DEPTH,
  parameter type entry_t = wr_entry_t
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  entry_t                   i_wrData,
  input  logic                     i_pop,
  output entry_t                   o_rdData,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic               w_doPush;
  logic               w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_rdData = r_mem[r_rdPtr];
  assign o_count  = r_count;

  // Storage needs no reset: the pointers alone decide which words are valid.
  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_reg_arbiter.sv
// Display register bank shared between processor MMIO writes and VGA reads.
// Writes queue up and are committed only during vertical blank, so a frame never tears.
module vga_reg_arbiter
  import vga_reg_pkg::*;
#(
  parameter int ADDR_W    = vga_reg_pkg::ADDR_W,
  parameter int DEPTH     = vga_reg_pkg::DEPTH,
  parameter int MAX_DRAIN = vga_reg_pkg::MAX_DRAIN,
  parameter int FC_W      = vga_reg_pkg::FC_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [31:0]              wr_data,
  output logic                     wr_full,
  output logic                     overflow,
  input  logic                     ovf_clear,
  input  logic                     vblank,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [31:0]              rd_data,
  output logic [FC_W-1:0]          frame_count,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     drain_active
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int DR_W = $clog2(MAX_DRAIN + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } entry_t;

  logic [31:0]      r_bank [NREG];
  logic [31:0]      r_rdData;
  logic [FC_W-1:0]  r_frameCount;
  logic             r_overflow;
  logic             r_vblankQ;
  logic [DR_W-1:0]  r_drained;
  state_t           r_state;

  entry_t           w_pushEntry;
  entry_t           w_popEntry;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic             w_rise;
  logic             w_budgetDone;
  logic             w_pop;

  assign w_pushEntry.addr = wr_addr;
  assign w_pushEntry.data = wr_data;

  reg_write_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_push   (wr_en),
    .i_wrData (w_pushEntry),
    .i_pop    (w_pop),
    .o_rdData (w_popEntry),
    .o_count  (fifo_count),
    .o_full   (w_fifoFull),
    .o_empty  (w_fifoEmpty)
  );

  assign w_rise       = vblank && !r_vblankQ;
  assign w_budgetDone = (r_drained == DR_W'(MAX_DRAIN));
  assign w_pop        = (r_state == S_DRAIN) && vblank && !w_fifoEmpty && !w_budgetDone;

  assign wr_full      = w_fifoFull;
  assign overflow     = r_overflow;
  assign rd_data      = r_rdData;
  assign frame_count  = r_frameCount;
  assign drain_active = (r_state == S_DRAIN);

  // vblank_q resets high so a blank already in progress at reset is not treated as a new frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_WAIT;
      r_drained <= '0;
      r_vblankQ <= 1'b1;
    end else begin
      r_vblankQ <= vblank;
      case (r_state)
        S_WAIT: begin
          if (w_rise) begin
            r_state   <= S_DRAIN;
            r_drained <= '0;
          end
        end
        S_DRAIN: begin
          if (!vblank) begin
            r_state <= S_WAIT;
          end else if (w_fifoEmpty || w_budgetDone) begin
            r_state <= S_HOLD;
          end else begin
            r_drained <= r_drained + DR_W'(1);
          end
        end
        S_HOLD: begin
          if (!vblank) begin
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frameCount <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_rise) begin
        r_frameCount <= r_frameCount + FC_W'(1);
      end
      if (ovf_clear) begin
        r_overflow <= 1'b0;
      end else if (wr_en && w_fifoFull) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // The read port samples the bank before any same-edge commit, so a new value shows a cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_bank[i] <= '0;
      end
      r_rdData <= '0;
    end else begin
      r_rdData <= r_bank[rd_addr];
      if (w_pop) begin
        r_bank[w_popEntry.addr] <= w_popEntry.data;
      end
    end
  end

endmodule
